// File: rtl/tilemap_addr_gen.sv
// Tilemap VRAM address generator: time-slices each 8-pixel tile period between CPU and
// per-layer video fetch, with per-line scroll fetch committed atomically on a tile boundary.
module tilemap_addr_gen #(
  parameter int NLAYERS = 2,
  localparam int LB = (NLAYERS == 4) ? 2 : 1,
  localparam int ADDRW = 11 + LB
) (
  input  logic               i_EMU_MCLK,
  input  logic               i_EMU_RST,
  input  logic               i_EMU_CLK6MPCEN_n,
  input  logic               i_HFLIP,
  input  logic               i_VFLIP,
  input  logic [8:0]         i_HCNT,
  input  logic [7:0]         i_VCNT,
  input  logic               i_VCLK,
  input  logic [ADDRW-1:0]   i_CPUADDR,
  input  logic [7:0]         i_GFXDATA,
  output logic [ADDRW-1:0]   o_VRAMADDR,
  output logic [2:0]         o_TILELINEADDR,
  output logic [NLAYERS-1:0] o_SHIFT,
  output logic [LB+1:0]      o_SCRADDR,
  output logic               o_SCRRD
);

  localparam int S = 8 / NLAYERS;
  localparam int NSTEP = 3 * NLAYERS;
  localparam logic [2-LB:0] TileLineOff = (3 - LB)'(S / 2);

  typedef enum logic [1:0] {StIdle, StFetch, StCommit} state_e;

  logic       en;
  logic [8:0] fh;
  logic [7:0] fv;
  logic [2:0] ph;
  logic [LB-1:0] lyr;
  logic [2-LB:0] off;

  assign en  = ~i_EMU_CLK6MPCEN_n;
  assign fh  = i_HCNT ^ {9{i_HFLIP}};
  assign fv  = i_VCNT ^ {8{i_VFLIP}};
  assign ph  = i_HCNT[2:0];
  assign lyr = ph[2 -: LB];
  assign off = ph[2-LB:0];

  logic [8:0] h_act [NLAYERS];
  logic [7:0] v_act [NLAYERS];
  logic [8:0] h_sh  [NLAYERS];
  logic [7:0] v_sh  [NLAYERS];

  // Address datapath
  logic [5:0]         htile;
  logic [7:0]         vsum;
  logic [ADDRW-1:0]   vram_d;
  logic [2:0]         tline_d;
  logic [NLAYERS-1:0] shift_d;

  always_comb begin
    htile   = h_act[lyr][8:3] + fh[8:3];
    vsum    = v_act[lyr] + fv;
    vram_d  = off[2-LB] ? {lyr, vsum[7:3], htile} : i_CPUADDR;
    tline_d = v_act[lyr][2:0] + fv[2:0];
    shift_d = '1;
    for (int k = 0; k < NLAYERS; k++) begin
      shift_d[k] = (3'(h_act[k][2:0] + fh[2:0]) != 3'd7);
    end
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
    if (i_EMU_RST) begin
      o_VRAMADDR     <= '0;
      o_TILELINEADDR <= '0;
      o_SHIFT        <= '1;
    end else if (en) begin
      o_VRAMADDR <= vram_d;
      o_SHIFT    <= shift_d;
      if (off == TileLineOff) o_TILELINEADDR <= tline_d;
    end
  end

  // Scroll-fetch FSM
  state_e        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [LB-1:0] flyr_q, flyr_d;
  logic [1:0]    fsel_q, fsel_d;
  logic          vclk_q;
  logic          reading, cap, commit, rd_d;
  logic [LB+1:0] scraddr_d;

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
    if (i_EMU_RST) begin
      state_q <= StIdle;
      step_q  <= '0;
      flyr_q  <= '0;
      fsel_q  <= '0;
      vclk_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      step_q  <= step_d;
      flyr_q  <= flyr_d;
      fsel_q  <= fsel_d;
      vclk_q  <= i_VCLK;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = '0;
    flyr_d  = '0;
    fsel_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (i_VCLK && !vclk_q) state_d = StFetch;
      end
      StFetch: begin
        step_d = step_q + 4'd1;
        fsel_d = (fsel_q == 2'd2) ? 2'd0 : fsel_q + 2'd1;
        flyr_d = (fsel_q == 2'd2) ? flyr_q + 1'b1 : flyr_q;
        if (step_q == 4'(NSTEP)) state_d = StCommit;
      end
      StCommit: begin
        if (ph == 3'd7) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    reading   = (state_q == StFetch) && (step_q < 4'(NSTEP));
    rd_d      = reading;
    scraddr_d = reading ? {flyr_q, fsel_q} : '0;
    // o_SCRADDR still holds the address issued on the previous enable
    cap       = (state_q == StFetch) && (step_q != 4'd0);
    commit    = (state_q == StCommit) && (ph == 3'd7);
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
    if (i_EMU_RST) begin
      o_SCRRD   <= 1'b0;
      o_SCRADDR <= '0;
    end else if (en) begin
      o_SCRRD   <= rd_d;
      o_SCRADDR <= scraddr_d;
    end
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
    if (i_EMU_RST) begin
      for (int k = 0; k < NLAYERS; k++) begin
        h_sh[k]  <= '0;
        v_sh[k]  <= '0;
        h_act[k] <= '0;
        v_act[k] <= '0;
      end
    end else if (en) begin
      if (cap) begin
        unique case (o_SCRADDR[1:0])
          2'd0:    h_sh[o_SCRADDR[LB+1:2]][7:0] <= i_GFXDATA;
          2'd1:    h_sh[o_SCRADDR[LB+1:2]][8]   <= i_GFXDATA[0];
          default: v_sh[o_SCRADDR[LB+1:2]]      <= i_GFXDATA;
        endcase
      end
      if (commit) begin
        h_act <= h_sh;
        v_act <= v_sh;
      end
    end
  end

endmodule

// File: tb/tb_tilemap_addr_gen.sv
// Directed bench for tilemap_addr_gen: 2-layer and 4-layer instances share stimulus.
module tb_tilemap_addr_gen;

  logic        clk = 1'b0, rst = 1'b1, cen_n = 1'b1;
  logic        hflip = 1'b0, vflip = 1'b0, vclk = 1'b0;
  logic [8:0]  hcnt = '0;
  logic [7:0]  vcnt = '0, gfx = '0;
  logic [11:0] cpu2 = 12'h5A5;
  logic [12:0] cpu4 = 13'h1ABC;

  logic [11:0] vaddr2;
  logic [2:0]  tl2, sa2;
  logic [1:0]  sh2;
  logic        rd2;
  logic [12:0] vaddr4;
  logic [2:0]  tl4;
  logic [3:0]  sh4, sa4;
  logic        rd4;

  int n_tests = 0, n_fail = 0;
  int n2, n4;

  logic [7:0] fbytes [6] = '{8'h1F, 8'h01, 8'h0F, 8'h08, 8'h00, 8'h00};
  logic [2:0] faddr  [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

  always #5 clk = ~clk;

  tilemap_addr_gen #(.NLAYERS(2)) dut2 (
    .i_EMU_MCLK(clk), .i_EMU_RST(rst), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_HFLIP(hflip), .i_VFLIP(vflip), .i_HCNT(hcnt), .i_VCNT(vcnt), .i_VCLK(vclk),
    .i_CPUADDR(cpu2), .i_GFXDATA(gfx), .o_VRAMADDR(vaddr2), .o_TILELINEADDR(tl2),
    .o_SHIFT(sh2), .o_SCRADDR(sa2), .o_SCRRD(rd2)
  );

  tilemap_addr_gen #(.NLAYERS(4)) dut4 (
    .i_EMU_MCLK(clk), .i_EMU_RST(rst), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_HFLIP(hflip), .i_VFLIP(vflip), .i_HCNT(hcnt), .i_VCNT(vcnt), .i_VCLK(vclk),
    .i_CPUADDR(cpu4), .i_GFXDATA(gfx), .o_VRAMADDR(vaddr4), .o_TILELINEADDR(tl4),
    .o_SHIFT(sh4), .o_SCRADDR(sa4), .o_SCRRD(rd4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One pixel enable with the given H count; returns at the following negedge.
  task automatic tick(input logic [8:0] h);
    @(negedge clk);
    hcnt  = h;
    cen_n = 1'b0;
    @(negedge clk);
    cen_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_vaddr", 32'(vaddr2), 32'h0);
    check_eq("rst_tline", 32'(tl2), 32'h0);
    check_eq("rst_shift2", 32'(sh2), 32'h3);
    check_eq("rst_shift4", 32'(sh4), 32'hF);
    check_eq("rst_scrrd", 32'(rd2), 32'h0);
    check_eq("rst_scraddr", 32'(sa2), 32'h0);
    rst = 1'b0;

    // No scroll: CPU and video slots
    tick(9'h010); check_eq("cpu_ph0", 32'(vaddr2), 32'h5A5);
    tick(9'h012); check_eq("vid_l0", 32'(vaddr2), 32'h002);
    tick(9'h016); check_eq("vid_l1", 32'(vaddr2), 32'h802);
    tick(9'h017); check_eq("shift_ph7", 32'(sh2), 32'h0);
    @(negedge clk); hcnt = 9'h010;
    repeat (3) @(negedge clk);
    check_eq("hold_no_en", 32'(vaddr2), 32'h802);

    // Scroll fetch, commit deferred to ph==7
    vclk = 1'b1; tick(9'h020); vclk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(9'(9'h021 + i));
      check_eq("fetch_rd", 32'(rd2), 32'h1);
      check_eq("fetch_addr", 32'(sa2), 32'(faddr[i]));
      gfx = fbytes[i];
    end
    tick(9'h027); check_eq("fetch_rd_end", 32'(rd2), 32'h0);
    gfx = 8'h00;
    for (int h = 9'h028; h < 9'h02E; h++) tick(9'(h));
    tick(9'h02E); check_eq("pre_commit", 32'(vaddr2), 32'h805);
    tick(9'h02F);

    vcnt = 8'h01;
    tick(9'h000); check_eq("shift_scrolled", 32'(sh2), 32'h2);
    tick(9'h002); check_eq("vid_scr_l0", 32'(vaddr2), 32'h0A3);
    check_eq("tline_l0", 32'(tl2), 32'h0);
    tick(9'h006); check_eq("vid_scr_l1", 32'(vaddr2), 32'h801);
    check_eq("tline_l1", 32'(tl2), 32'h1);

    // Async reset, then horizontal flip with zero scroll
    @(negedge clk); rst = 1'b1; #1;
    check_eq("rst_async", 32'(vaddr2), 32'h0);
    @(negedge clk); rst = 1'b0; vcnt = 8'h00; hflip = 1'b1;
    tick(9'h000); check_eq("hflip_shift", 32'(sh2), 32'h0);
    tick(9'h002); check_eq("hflip_l0", 32'(vaddr2), 32'h03F);
    tick(9'h006); check_eq("hflip_l1", 32'(vaddr2), 32'h83F);
    hflip = 1'b0;

    // Reset in the middle of a fetch
    vclk = 1'b1; tick(9'h000); vclk = 1'b0;
    gfx = 8'hFF;
    tick(9'h001); tick(9'h002); tick(9'h003);
    @(negedge clk); #2 rst = 1'b1; #1;
    check_eq("midrst_rd", 32'(rd2), 32'h0);
    check_eq("midrst_sa", 32'(sa2), 32'h0);
    check_eq("midrst_vaddr", 32'(vaddr2), 32'h0);
    check_eq("midrst_shift", 32'(sh2), 32'h3);
    @(negedge clk); rst = 1'b0; gfx = 8'h00;
    tick(9'h00A); check_eq("midrst_active", 32'(vaddr2), 32'h001);

    // Full fetch on both instances; second VCLK pulse mid-fetch is ignored
    n2 = 0; n4 = 0;
    vclk = 1'b1; tick(9'h000); vclk = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 3) vclk = 1'b1;
      if (i == 5) vclk = 1'b0;
      tick(9'(i + 1));
      if (rd2) n2++;
      if (rd4) n4++;
      if (i == 0) begin
        check_eq("refetch_sa2", 32'(sa2), 32'h0);
        check_eq("refetch_sa4", 32'(sa4), 32'h0);
      end
    end
    check_eq("reads_2l", 32'(n2), 32'd6);
    check_eq("reads_4l", 32'(n4), 32'd12);
    check_eq("rd4_idle", 32'(rd4), 32'h0);

    // Four-layer slot map
    for (int p = 0; p < 8; p++) begin
      tick(9'(p));
      if (p % 2 == 1) check_eq("l4_slot", 32'(vaddr4), 32'((p / 2) << 11));
      else            check_eq("l4_cpu", 32'(vaddr4), 32'h1ABC);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
